// File: rtl/counter_updown_presc.sv
// Parametrised up/down counter with [MIN_CNT..MAX_CNT] range, wrap/saturate mode,
// synchronous clear/load and an enable prescaler.
// Optional feature: define CNT_OVF_COUNT_EN to add the saturating terminal-tick counter ovfCntOut.
module counter_updown_presc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MIN_CNT  = 0,
  parameter int unsigned MAX_CNT  = 255,
  parameter int unsigned LOOP     = 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             enIn,
  input  logic             dirIn,
  input  logic             clrIn,
  input  logic             loadIn,
  input  logic [WIDTH-1:0] loadValIn,
  output logic [WIDTH-1:0] cntValOut,
  output logic             cntDoneOut,
`ifdef CNT_OVF_COUNT_EN
  output logic [7:0]       ovfCntOut,
`endif
  output logic             atMaxOut,
  output logic             atMinOut
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MIN_V      = WIDTH'(MIN_CNT);
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_CNT);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam bit               LOOP_EN    = (LOOP != 0);

  // Reject parameter sets that would let the count leave its register range.
  if ((MIN_CNT >= MAX_CNT) || (PRESCALE < 1) ||
      (longint'(MAX_CNT) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_params
    $fatal(1, "counter_updown_presc: invalid parameters");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             tick;

  // Next-state: clear beats load beats tick; terminal values are compared before stepping.
  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    tick    = enIn && (presc_q == PRESC_LAST);
    if (clrIn) begin
      cnt_d   = MIN_V;
      presc_d = '0;
    end else if (loadIn) begin
      presc_d = '0;
      if (loadValIn < MIN_V)      cnt_d = MIN_V;
      else if (loadValIn > MAX_V) cnt_d = MAX_V;
      else                        cnt_d = loadValIn;
    end else if (enIn) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (!dirIn) begin
          if (cnt_q == MAX_V) begin
            done_d = 1'b1;
            cnt_d  = LOOP_EN ? MIN_V : MAX_V;
          end else begin
            cnt_d  = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == MIN_V) begin
            done_d = 1'b1;
            cnt_d  = LOOP_EN ? MAX_V : MIN_V;
          end else begin
            cnt_d  = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // Count, prescaler phase and terminal pulse registers.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      cnt_q   <= MIN_V;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

`ifdef CNT_OVF_COUNT_EN
  logic [7:0] ovf_q, ovf_d;

  // Saturating count of terminal ticks; load leaves it alone, clear zeroes it.
  always_comb begin
    ovf_d = ovf_q;
    if (clrIn)                          ovf_d = '0;
    else if (done_d && ovf_q != 8'hFF)  ovf_d = ovf_q + 8'd1;
  end

  // Terminal-tick counter register.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovfCntOut = ovf_q;
`endif

  assign cntValOut  = cnt_q;
  assign cntDoneOut = done_q;
  assign atMaxOut   = (cnt_q == MAX_V);
  assign atMinOut   = (cnt_q == MIN_V);

endmodule
